// File: rtl/rcs_pkg.sv
// Shared types and constants for the rcs_seq_ctrl sliced subtractor sequencer.
// Optional macro RCS_SEQ_OVF_EN adds signed-overflow reporting in rcs_seq_ctrl.
package rcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rcs_state_e;

    localparam int RCS_W_DEF = 128;
    localparam int RCS_G_DEF = 32;

    // Slice counter width; a single-slice build still needs a 1-bit counter.
    function automatic int rcs_cnt_w(input int nslice);
        int w;
        w = $clog2(nslice);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rcs_slice.sv
// G-bit combinational ripple-borrow subtractor: d = x - y - bi, bo = borrow out.
module rcs_slice #(
    parameter int G = 32
) (
    input  logic [G-1:0] x,
    input  logic [G-1:0] y,
    input  logic         bi,
    output logic [G-1:0] d,
    output logic         bo
);

    // Each cell keeps its own borrow nets so the chain is not one self-referencing vector.
    for (genvar gi = 0; gi < G; gi++) begin : g_fs
        logic b_in;
        logic b_out;

        if (gi == 0) begin : g_first
            assign b_in = bi;
        end else begin : g_rest
            assign b_in = g_fs[gi-1].b_out;
        end

        assign d[gi]  = x[gi] ^ y[gi] ^ b_in;
        assign b_out  = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & b_in);
    end

    assign bo = g_fs[G-1].b_out;

endmodule

// File: rtl/rcs_seq_ctrl.sv
// Multi-cycle W-bit subtractor: a - b - bin, one G-bit slice per cycle through rcs_slice.
// Define RCS_SEQ_OVF_EN to add the 'ovf' signed-overflow output.
module rcs_seq_ctrl
    import rcs_pkg::*;
#(
    parameter int W = RCS_W_DEF,
    parameter int G = RCS_G_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
`ifdef RCS_SEQ_OVF_EN
    output logic         ovf,
`endif
    output logic         bout
);

    localparam int NSLICE = W / G;
    localparam int CW     = rcs_cnt_w(NSLICE);

    if (G < 1 || (W % G) != 0) begin : g_bad_cfg
        $error("rcs_seq_ctrl: W (%0d) must be a positive multiple of G (%0d)", W, G);
    end

    rcs_state_e     state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   diff_q, diff_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           brw_q, brw_d;
    logic           bout_q, bout_d;
`ifdef RCS_SEQ_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    logic [G-1:0]   slice_diff;
    logic           slice_bo;
    logic [W-1:0]   diff_shift;
    logic           accept;
    logic           last;

    rcs_slice #(.G(G)) u_slice (
        .x  (a_q[G-1:0]),
        .y  (b_q[G-1:0]),
        .bi (brw_q),
        .d  (slice_diff),
        .bo (slice_bo)
    );

    // Slice results enter at the MSB end, so after NSLICE shifts slice 0 sits at the bottom.
    if (NSLICE == 1) begin : g_one_slice
        assign diff_shift = slice_diff;
    end else begin : g_multi_slice
        assign diff_shift = {slice_diff, diff_q[W-1:G]};
    end

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last   = (cnt_q == CW'(NSLICE - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
`ifdef RCS_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif

        if (accept) begin
            state_d = ST_RUN;
            a_d     = a;
            b_d     = b;
            brw_d   = bin;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    diff_d = diff_shift;
                    brw_d  = slice_bo;
                    a_d    = a_q >> G;
                    b_d    = b_q >> G;
                    if (last) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        bout_d  = slice_bo;
`ifdef RCS_SEQ_OVF_EN
                        // Top slice MSBs are the operand sign bits on the final cycle.
                        ovf_d   = (a_q[G-1] != b_q[G-1]) && (slice_diff[G-1] != a_q[G-1]);
`endif
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
`ifdef RCS_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
`ifdef RCS_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef RCS_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_rcs_seq_ctrl.sv
// Self-checking bench for rcs_seq_ctrl (W=128, G=32) against a whole-word arithmetic model.
module tb_rcs_seq_ctrl;

    localparam int W      = 128;
    localparam int G      = 32;
    localparam int NSLICE = W / G;

    typedef logic [W:0] lw_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef RCS_SEQ_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rcs_seq_ctrl #(.W(W), .G(G)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef RCS_SEQ_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    task automatic check(input string tag, input lw_t obs, input lw_t exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: top bit of the (W+1)-bit result is the borrow (a < b + bin).
    function automatic lw_t ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        return {1'b0, av} - {1'b0, bv} - lw_t'(bi);
    endfunction

`ifdef RCS_SEQ_OVF_EN
    // Signed overflow: exact signed result falls outside the W-bit two's-complement range.
    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        logic signed [W+1:0] r;
        r = $signed({{2{av[W-1]}}, av}) - $signed({{2{bv[W-1]}}, bv}) - $signed({{(W+1){1'b0}}, bi});
        return (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
    endfunction
`endif

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge where start may be accepted; returns at the negedge of RUN cycle 1.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = bi;
        @(negedge clk);
        start = 1'b0;
        a     = rnd_w();
        b     = rnd_w();
        bin   = 1'($urandom_range(0, 1));
    endtask

    // Checks the RUN window and the done cycle; inject_k>0 pulses start in that RUN cycle.
    task automatic track(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input int inject_k);
        lw_t r;
        r = ref_sub(av, bv, bi);
        for (int k = 1; k <= NSLICE; k++) begin
            check("busy_run", lw_t'(busy), lw_t'(1));
            check("done_run", lw_t'(done), lw_t'(0));
            if (k == inject_k) begin
                start = 1'b1;
                a     = rnd_w();
                b     = rnd_w();
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("done_pulse", lw_t'(done), lw_t'(1));
        check("busy_done", lw_t'(busy), lw_t'(0));
        check("diff", lw_t'(diff), lw_t'(r[W-1:0]));
        check("bout", lw_t'(bout), lw_t'(r[W]));
`ifdef RCS_SEQ_OVF_EN
        check("ovf", lw_t'(ovf), lw_t'(ref_ovf(av, bv, bi)));
`endif
        $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d", av, bv, bi, diff, bout);
    endtask

    // One cycle after done without a new start: back to idle, result held.
    task automatic idle_chk(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        lw_t r;
        r = ref_sub(av, bv, bi);
        @(negedge clk);
        check("done_idle", lw_t'(done), lw_t'(0));
        check("busy_idle", lw_t'(busy), lw_t'(0));
        check("diff_held", lw_t'(diff), lw_t'(r[W-1:0]));
        check("bout_held", lw_t'(bout), lw_t'(r[W]));
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input int inject_k);
        launch(av, bv, bi);
        track(av, bv, bi, inject_k);
        idle_chk(av, bv, bi);
    endtask

    initial begin
        logic [W-1:0] av, bv, bv2;
        logic         bi;
        int           seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", lw_t'(busy), lw_t'(0));
        check("rst_done", lw_t'(done), lw_t'(0));
        check("rst_diff", lw_t'(diff), lw_t'(0));
        check("rst_bout", lw_t'(bout), lw_t'(0));
`ifdef RCS_SEQ_OVF_EN
        check("rst_ovf", lw_t'(ovf), lw_t'(0));
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        op(W'(5), W'(3), 1'b0, 0);
        op('0, W'(1), 1'b0, 0);
        op('0, '0, 1'b1, 0);
        op(W'(1) << 32, W'(1), 1'b0, 0);
        op({W{1'b1}}, {W{1'b1}}, 1'b1, 0);
        op(W'(5), W'(3), 1'b0, 2);

        // Back-to-back: second start in the DONE cycle
        launch(W'(5), W'(3), 1'b0);
        track(W'(5), W'(3), 1'b0, 0);
        bv2 = W'(1) << 64;
        launch(W'(7), bv2, 1'b1);
        track(W'(7), bv2, 1'b1, 0);
        idle_chk(W'(7), bv2, 1'b1);

`ifdef RCS_SEQ_OVF_EN
        op(W'(1) << (W - 1), W'(1), 1'b0, 0);
        op(W'(7), W'(3), 1'b0, 0);
`endif

        // Reset in RUN cycle 2 aborts with no done pulse
        launch(rnd_w(), rnd_w(), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", lw_t'(busy), lw_t'(0));
        check("abort_done", lw_t'(done), lw_t'(0));
        check("abort_diff", lw_t'(diff), lw_t'(0));
        check("abort_bout", lw_t'(bout), lw_t'(0));
        seen = 0;
        repeat (NSLICE + 3) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("abort_no_done", lw_t'(seen), lw_t'(0));
        op(W'(100), W'(42), 1'b1, 0);

        // Randomized operations, with random start injection and back-to-back chaining
        for (int i = 0; i < 40; i++) begin
            av = rnd_w();
            case ($urandom_range(0, 3))
                0: bv = rnd_w();
                1: bv = av;
                2: bv = av + W'($urandom_range(0, 2)) - W'(1);
                default: begin
                    av = W'($urandom_range(0, 15));
                    bv = W'($urandom_range(0, 15));
                end
            endcase
            bi = 1'($urandom_range(0, 1));
            launch(av, bv, bi);
            track(av, bv, bi, int'($urandom_range(0, NSLICE)));
            if ($urandom_range(0, 1) == 1) idle_chk(av, bv, bi);
        end
        idle_chk(av, bv, bi);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
